// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths, fetch state encoding and the
// IF/ID bundle that the decode stage will also consume.
package pipeline_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instruction;
      logic            valid;
   } if_id_t;

   // Instruction addresses are word aligned; the low two bits are dropped.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return addr & {{(XLEN-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register with load, hold and clear; clear wins over load.
// Sized for the IF/ID bundle by default, reusable for later stage registers.
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter int WIDTH = $bits(if_id_t)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN control and the IF/ID register.
// Optional saturating fetch/bubble counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [XLEN-1:0] PC_STEP  = 64'd4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic [XLEN-1:0] Inst_Address,
   input  logic [ILEN-1:0] Instruction,
   output logic [XLEN-1:0] ifid_pc,
   output logic [ILEN-1:0] ifid_instruction,
   output logic            ifid_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     fetch_count,
   output logic [31:0]     bubble_count
`endif
);

   fetch_state_t    state;
   fetch_state_t    next_state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   logic            ifid_load;
   logic            ifid_clear;
   if_id_t          ifid_d;
   if_id_t          ifid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         state <= next_state;
      end
   end

   // Redirect beats stall; BOOT ignores both so the first fetch is always RESET_PC.
   always_comb begin
      next_state = state;
      pc_next    = pc;
      ifid_load  = 1'b0;
      ifid_clear = 1'b0;
      case (state)
         BOOT: begin
            next_state = RUN;
         end
         RUN: begin
            if (branch_taken) begin
               pc_next    = align_pc(branch_target);
               ifid_clear = 1'b1;
            end else if (!stall) begin
               pc_next   = pc + PC_STEP;
               ifid_load = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

   assign Inst_Address = pc;

   assign ifid_d.pc          = pc;
   assign ifid_d.instruction = Instruction;
   assign ifid_d.valid       = 1'b1;

   if_id_reg #(
      .WIDTH($bits(if_id_t))
   ) u_if_id_reg (
      .clk  (clk),
      .reset(reset),
      .load (ifid_load),
      .clear(ifid_clear),
      .d    (ifid_d),
      .q    (ifid_q)
   );

   assign ifid_pc          = ifid_q.pc;
   assign ifid_instruction = ifid_q.instruction;
   assign ifid_valid       = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count  <= '0;
         bubble_count <= '0;
      end else begin
         if (ifid_load && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if ((state == RUN) && (branch_taken || stall) &&
             (bubble_count != 32'hFFFF_FFFF)) begin
            bubble_count <= bubble_count + 32'd1;
         end
      end
   end
`endif

endmodule
